pc_sequencer: RTL and testbench

Next-generation program-counter sequencer for the single-cycle MIPS core. It replaces the fixed PC+4/branch/jump update with a parametrised unit. Added behaviour: configurable reset and exception vectors, pipeline stall, register-indirect jumps (jr/jalr), exception entry with EPC/Cause capture, exception return (eret), target-misalignment faults and a retired-instruction counter. It sits between the control unit/register file and the instruction memory address port.

---
 rtl/pc_sequencer_if.sv | 39 +++
 rtl/pc_sequencer.sv | 96 +++++++++
 tb/tb_pc_sequencer.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: groups the control inputs and the architectural outputs of
// the program-counter sequencer.
//   master : control unit / register file side (drives controls, reads PC state)
//   slave  : the sequencer itself
// Signal semantics: there is no handshake; every control is a level sampled
// once on each rising clock edge, and every output is valid for the whole cycle.
interface pc_sequencer_if #(
  parameter int CNT_WIDTH = 32
);
  logic                 Stall;
  logic                 PCSrc;
  logic                 Jump;
  logic                 JumpReg;
  logic [31:0]          SignImm;
  logic [25:0]          Jump_low_26Bit;
  logic [31:0]          RegTarget;
  logic                 Exc;
  logic [4:0]           ExcCode;
  logic                 Eret;
  logic [31:0]          PC;
  logic [31:0]          PCPlus4;
  logic [31:0]          EPC;
  logic [4:0]           Cause;
  logic                 ExcActive;
  logic                 DoubleFault;
  logic [CNT_WIDTH-1:0] InstRet;

  modport master (
    output Stall, PCSrc, Jump, JumpReg, SignImm, Jump_low_26Bit, RegTarget,
           Exc, ExcCode, Eret,
    input  PC, PCPlus4, EPC, Cause, ExcActive, DoubleFault, InstRet
  );

  modport slave (
    input  Stall, PCSrc, Jump, JumpReg, SignImm, Jump_low_26Bit, RegTarget,
           Exc, ExcCode, Eret,
    output PC, PCPlus4, EPC, Cause, ExcActive, DoubleFault, InstRet
  );
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter sequencer for the single-cycle MIPS core.
// Computes the next fetch address from branch / jump / register-jump controls,
// handles exception entry (EPC/Cause capture), eret, target-misalignment
// faults (AdEL) and keeps a retired-instruction counter.
// Ports:
//   clk   : clock, all state updates on the rising edge
//   rst_n : synchronous reset, ACTIVE-HIGH despite the name
//   bus   : pc_sequencer_if.slave (controls in, PC/EPC/Cause/flags/InstRet out)
// The handler-mode flag ExcActive is the only FSM state and is exported as-is.
module pc_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR   = 32'h0000_0180,
  parameter int          CNT_WIDTH    = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  pc_sequencer_if.slave   bus
);

  localparam logic [0:0] MODE_NORMAL  = 1'b0;
  localparam logic [0:0] MODE_HANDLER = 1'b1;
  localparam logic [4:0] CODE_ADEL    = 5'd4;

  logic [31:0]          pc_q;
  logic [31:0]          epc_q;
  logic [4:0]           cause_q;
  logic [0:0]           mode_q;
  logic                 dfault_q;
  logic [CNT_WIDTH-1:0] inst_ret_q;

  logic [31:0] pc_plus4;
  logic [31:0] pc_branch;
  logic [31:0] pc_jump;
  logic [31:0] pc_seq;
  logic        misalign;
  logic        take_exc;
  logic [4:0]  exc_code;
  logic        do_eret;

  assign pc_plus4  = pc_q + 32'd4;
  assign pc_branch = pc_plus4 + {bus.SignImm[29:0], 2'b00};
  assign pc_jump   = {pc_plus4[31:28], bus.Jump_low_26Bit, 2'b00};

  // Only register targets can be misaligned; branch/jump targets are word
  // aligned by construction.
  assign misalign = bus.JumpReg && (bus.RegTarget[1:0] != 2'b00);
  assign take_exc = bus.Exc || misalign;
  // An external request outranks a simultaneous misalignment fault.
  assign exc_code = bus.Exc ? bus.ExcCode : CODE_ADEL;
  // eret outside handler mode falls through to normal sequencing.
  assign do_eret  = bus.Eret && (mode_q == MODE_HANDLER);

  always_comb begin
    pc_seq = pc_plus4;
    if (bus.JumpReg)    pc_seq = bus.RegTarget;
    else if (bus.Jump)  pc_seq = pc_jump;
    else if (bus.PCSrc) pc_seq = pc_branch;
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      pc_q       <= RESET_VECTOR;
      epc_q      <= 32'd0;
      cause_q    <= 5'd0;
      mode_q     <= MODE_NORMAL;
      dfault_q   <= 1'b0;
      inst_ret_q <= '0;
    end else if (take_exc) begin
      // Exception entry does not retire the instruction.
      pc_q <= EXC_VECTOR;
      if (mode_q == MODE_NORMAL) begin
        epc_q   <= pc_q;
        cause_q <= exc_code;
        mode_q  <= MODE_HANDLER;
      end else begin
        dfault_q <= 1'b1;
      end
    end else if (do_eret) begin
      pc_q       <= epc_q + 32'd4;
      mode_q     <= MODE_NORMAL;
      inst_ret_q <= inst_ret_q + 1'b1;
    end else if (!bus.Stall) begin
      pc_q       <= pc_seq;
      inst_ret_q <= inst_ret_q + 1'b1;
    end
  end

  assign bus.PC          = pc_q;
  assign bus.PCPlus4     = pc_plus4;
  assign bus.EPC         = epc_q;
  assign bus.Cause       = cause_q;
  assign bus.ExcActive   = mode_q[0];
  assign bus.DoubleFault = dfault_q;
  assign bus.InstRet     = inst_ret_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed testbench for pc_sequencer. A default (32-bit
// counter) instance and an 8-bit-counter instance receive identical controls.
module tb_pc_sequencer;

  logic clk = 1'b0;
  logic rst_n;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  pc_sequencer_if #(.CNT_WIDTH(32)) b32 ();
  pc_sequencer_if #(.CNT_WIDTH(8))  b8  ();

  pc_sequencer #(.CNT_WIDTH(32)) dut (.clk(clk), .rst_n(rst_n), .bus(b32));
  pc_sequencer #(.CNT_WIDTH(8))  dut8 (.clk(clk), .rst_n(rst_n), .bus(b8));

  assign b8.Stall          = b32.Stall;
  assign b8.PCSrc          = b32.PCSrc;
  assign b8.Jump           = b32.Jump;
  assign b8.JumpReg        = b32.JumpReg;
  assign b8.SignImm        = b32.SignImm;
  assign b8.Jump_low_26Bit = b32.Jump_low_26Bit;
  assign b8.RegTarget      = b32.RegTarget;
  assign b8.Exc            = b32.Exc;
  assign b8.ExcCode        = b32.ExcCode;
  assign b8.Eret           = b32.Eret;

  task automatic idle();
    b32.Stall = 1'b0; b32.PCSrc = 1'b0; b32.Jump = 1'b0; b32.JumpReg = 1'b0;
    b32.SignImm = 32'd0; b32.Jump_low_26Bit = 26'd0; b32.RegTarget = 32'd0;
    b32.Exc = 1'b0; b32.ExcCode = 5'd0; b32.Eret = 1'b0;
  endtask

  // One clock edge; outputs are sampled 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag, input logic [31:0] pc, input logic [31:0] epc,
                           input logic [4:0] cause, input logic act, input logic df,
                           input logic [31:0] ir);
    chk({tag, ".pc"},    64'(b32.PC), 64'(pc));
    chk({tag, ".epc"},   64'(b32.EPC), 64'(epc));
    chk({tag, ".cause"}, 64'(b32.Cause), 64'(cause));
    chk({tag, ".act"},   64'(b32.ExcActive), 64'(act));
    chk({tag, ".df"},    64'(b32.DoubleFault), 64'(df));
    chk({tag, ".ir"},    64'(b32.InstRet), 64'(ir));
  endtask

  task automatic jr_to(input logic [31:0] t);
    idle(); b32.JumpReg = 1'b1; b32.RegTarget = t; step(); idle();
  endtask

  initial begin
    idle();
    rst_n = 1'b1;
    step();
    chk_state("reset", 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 32'd0);
    chk("reset.pcplus4", 64'(b32.PCPlus4), 64'h4);
    chk("reset.ir8", 64'(b8.InstRet), 64'h0);

    rst_n = 1'b0;
    step(); chk("idle1.pc", 64'(b32.PC), 64'h4);
    step(); chk("idle2.pc", 64'(b32.PC), 64'h8);
    step(); chk("idle3.pc", 64'(b32.PC), 64'hC);
    chk("idle3.ir", 64'(b32.InstRet), 64'd3);

    // Branch backwards: 0x104 + (-2 << 2) = 0xFC
    jr_to(32'h100);
    chk("jr.pc", 64'(b32.PC), 64'h100);
    b32.PCSrc = 1'b1; b32.SignImm = 32'hFFFF_FFFE; step(); idle();
    chk("branch.pc", 64'(b32.PC), 64'hFC);
    chk("branch.ir", 64'(b32.InstRet), 64'd5);

    // Absolute jump keeps the upper nibble of PC+4
    jr_to(32'h1000_0000);
    b32.Jump = 1'b1; b32.Jump_low_26Bit = 26'h10; step(); idle();
    chk("jump.pc", 64'(b32.PC), 64'h1000_0040);
    // Jump has priority over PCSrc, JumpReg over Jump
    b32.Jump = 1'b1; b32.Jump_low_26Bit = 26'h20; b32.PCSrc = 1'b1; b32.SignImm = 32'h40;
    step(); idle();
    chk("jump_over_branch.pc", 64'(b32.PC), 64'h1000_0080);
    b32.JumpReg = 1'b1; b32.RegTarget = 32'h20; b32.Jump = 1'b1; b32.PCSrc = 1'b1;
    step(); idle();
    chk("jr_over_jump.pc", 64'(b32.PC), 64'h20);
    chk("jr_over_jump.ir", 64'(b32.InstRet), 64'd9);

    // Stall holds PC and counter, even with other controls asserted
    b32.Stall = 1'b1; step();
    chk_state("stall1", 32'h20, 32'h0, 5'd0, 1'b0, 1'b0, 32'd9);
    b32.PCSrc = 1'b1; b32.SignImm = 32'h10; step();
    chk_state("stall2", 32'h20, 32'h0, 5'd0, 1'b0, 1'b0, 32'd9);

    // Exception overrides stall
    idle(); b32.Stall = 1'b1; b32.Exc = 1'b1; b32.ExcCode = 5'd12; step(); idle();
    chk_state("exc", 32'h180, 32'h20, 5'd12, 1'b1, 1'b0, 32'd9);

    // Eret overrides stall
    b32.Eret = 1'b1; b32.Stall = 1'b1; step(); idle();
    chk_state("eret1", 32'h24, 32'h20, 5'd12, 1'b0, 1'b0, 32'd10);

    // Misaligned register jump -> AdEL
    b32.JumpReg = 1'b1; b32.RegTarget = 32'h202; step(); idle();
    chk_state("adel", 32'h180, 32'h24, 5'd4, 1'b1, 1'b0, 32'd10);
    b32.Eret = 1'b1; step(); idle();
    chk_state("eret2", 32'h28, 32'h24, 5'd4, 1'b0, 1'b0, 32'd11);

    // Eret outside handler mode is ordinary sequencing
    b32.Eret = 1'b1; step(); idle();
    chk_state("eret_noop", 32'h2C, 32'h24, 5'd4, 1'b0, 1'b0, 32'd12);

    // Double fault
    b32.Exc = 1'b1; b32.ExcCode = 5'd8; step(); idle();
    chk_state("exc2", 32'h180, 32'h2C, 5'd8, 1'b1, 1'b0, 32'd12);
    step();
    chk("handler.pc", 64'(b32.PC), 64'h184);
    b32.Exc = 1'b1; b32.ExcCode = 5'd3; step(); idle();
    chk_state("dfault", 32'h180, 32'h2C, 5'd8, 1'b1, 1'b1, 32'd13);
    b32.Eret = 1'b1; step(); idle();
    chk_state("dfault_sticky", 32'h30, 32'h2C, 5'd8, 1'b0, 1'b1, 32'd14);

    // Reset wins over a simultaneous exception
    rst_n = 1'b1; b32.Exc = 1'b1; b32.ExcCode = 5'd9; step(); idle();
    chk_state("rst_exc", 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 32'd0);
    rst_n = 1'b0;

    // Exc and misalignment together: Exc's code is recorded
    b32.Exc = 1'b1; b32.ExcCode = 5'd7; b32.JumpReg = 1'b1; b32.RegTarget = 32'h3;
    step(); idle();
    chk_state("exc_vs_adel", 32'h180, 32'h0, 5'd7, 1'b1, 1'b0, 32'd0);
    b32.Eret = 1'b1; step(); idle();
    chk("eret3.pc", 64'(b32.PC), 64'h4);

    // PC wraps at the top of the address space
    jr_to(32'hFFFF_FFFC);
    chk("top.pcplus4", 64'(b32.PCPlus4), 64'h0);
    step();
    chk("wrap.pc", 64'(b32.PC), 64'h0);

    // Counter wrap on the 8-bit instance
    rst_n = 1'b1; step(); rst_n = 1'b0;
    for (int i = 0; i < 255; i++) step();
    chk("ir8.255", 64'(b8.InstRet), 64'd255);
    step();
    chk("ir8.wrap", 64'(b8.InstRet), 64'd0);
    chk("ir32.256", 64'(b32.InstRet), 64'd256);
    chk("pc.256", 64'(b32.PC), 64'h400);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
